// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit and its branch history table.
//   bht_state_t  : BHT sweep FSM states (INIT clears the table, READY serves)
//   instr_kind_t : control-flow class of the instruction sitting in EX
package branch_resolve_unit_pkg;

    typedef enum logic {
        BHT_INIT,
        BHT_READY
    } bht_state_t;

    typedef enum logic [1:0] {
        KIND_OTHER,
        KIND_BRANCH,
        KIND_JAL,
        KIND_JALR
    } instr_kind_t;

    // True for anything that can redirect fetch.
    function automatic logic is_control_flow(input instr_kind_t kind);
        return kind != KIND_OTHER;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_2bit.sv
// bht_2bit: table of 2-bit saturating direction counters.
//   clk, rst      : clock, asynchronous active-high reset (restarts the init sweep)
//   lookup_idx    : fetch-side read index
//   lookup_taken  : counter MSB for lookup_idx; forced 0 until the sweep is done
//   upd_en        : train the counter at upd_idx this edge
//   upd_idx       : training index
//   upd_taken     : resolved direction (+1 when taken, -1 when not)
//   ready         : registered; low while the init sweep walks the table
module bht_2bit
    import branch_resolve_unit_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_INIT    = 1,
    localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken,
    output logic             ready
);

    bht_state_t       state;
    logic [IDX_W-1:0] sweep_idx;
    logic [1:0]       ctr_mem [BHT_ENTRIES];

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic up);
        if (up) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

    // Sweep FSM: one entry per cycle, then READY until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BHT_INIT;
            sweep_idx <= '0;
            ready     <= 1'b0;
        end else begin
            case (state)
                BHT_INIT: begin
                    if (sweep_idx == IDX_W'(BHT_ENTRIES - 1)) begin
                        state <= BHT_READY;
                        ready <= 1'b1;
                    end
                    sweep_idx <= sweep_idx + IDX_W'(1);
                end
                default: begin
                    state <= BHT_READY;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Counter storage carries no reset; the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (state == BHT_INIT) begin
            ctr_mem[sweep_idx] <= 2'(CTR_INIT);
        end else if (upd_en) begin
            ctr_mem[upd_idx] <= sat_step(ctr_mem[upd_idx], upd_taken);
        end
    end

    // Read is combinational off the array, so a same-cycle update is not visible yet.
    assign lookup_taken = ready & ctr_mem[lookup_idx][1];

endmodule

// File: rtl/parameters.vh
// Shared RISC-V encoding constants used by the execute-stage units.
// Opcodes are the 7-bit major opcodes; FUNC3_* are the conditional-branch
// condition encodings carried in instr[14:12].
`ifndef PARAMETERS_VH
`define PARAMETERS_VH

`define OPCODE_BRANCH 7'b1100011
`define OPCODE_JAL    7'b1101111
`define OPCODE_JALR   7'b1100111

`define FUNC3_BEQ     3'b000
`define FUNC3_BNE     3'b001
`define FUNC3_BLT     3'b100
`define FUNC3_BGE     3'b101
`define FUNC3_BLTU    3'b110
`define FUNC3_BGEU    3'b111

`endif

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-stage resolver for BEQ..BGEU / JAL / JALR.
// Compares the resolved outcome with the prediction carried from fetch and
// registers valid/taken/flush/redirect/misaligned one cycle later. Owns the
// BHT that fetch reads (i_lookup_pc) and EX trains (conditional branches).
//   clk, rst        : clock, asynchronous active-high reset
//   i_valid/i_stall : EX instruction valid / downstream stall (holds outputs)
//   i_pc, i_opcode, i_func3, i_rs1_data, i_rs2_data, i_imm : EX instruction
//   i_pred_taken, i_pred_pc : fetch prediction for this instruction
//   i_lookup_pc / o_lookup_taken : BHT read port for fetch
//   o_ready         : low during the BHT init sweep
//   o_valid, o_taken, o_flush, o_redirect_pc, o_misaligned : registered result
`include "parameters.vh"

module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_INIT    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    input  logic            i_stall,
    input  logic [XLEN-1:0] i_pc,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_func3,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_pc,
    input  logic [XLEN-1:0] i_lookup_pc,
    output logic            o_lookup_taken,
    output logic            o_ready,
    output logic            o_valid,
    output logic            o_taken,
    output logic            o_flush,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_misaligned
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    // ---- p0: decode, condition evaluation, targets, prediction check ----
    instr_kind_t            kind_p0;
    logic                   cond_known_p0;
    logic                   cond_true_p0;
    logic signed [XLEN-1:0] rs1_s_p0;
    logic signed [XLEN-1:0] rs2_s_p0;
    logic [XLEN-1:0]        jalr_sum_p0;
    logic [XLEN-1:0]        target_p0;
    logic [XLEN-1:0]        fall_pc_p0;
    logic [XLEN-1:0]        redirect_p0;
    logic                   taken_p0;
    logic                   misaligned_p0;
    logic                   flush_p0;
    logic                   accept_p0;
    logic                   bht_upd_p0;

    logic                   vld_p1;
    logic                   taken_p1;
    logic                   flush_p1;
    logic                   misaligned_p1;
    logic [XLEN-1:0]        redirect_p1;

    logic                   unused_lookup_bits;

    assign rs1_s_p0 = i_rs1_data;
    assign rs2_s_p0 = i_rs2_data;

    always_comb begin
        kind_p0 = KIND_OTHER;
        case (i_opcode)
            `OPCODE_BRANCH: kind_p0 = KIND_BRANCH;
            `OPCODE_JAL:    kind_p0 = KIND_JAL;
            `OPCODE_JALR:   kind_p0 = KIND_JALR;
            default:        kind_p0 = KIND_OTHER;
        endcase
    end

    always_comb begin
        cond_known_p0 = 1'b1;
        cond_true_p0  = 1'b0;
        case (i_func3)
            `FUNC3_BEQ:  cond_true_p0 = (i_rs1_data == i_rs2_data);
            `FUNC3_BNE:  cond_true_p0 = (i_rs1_data != i_rs2_data);
            `FUNC3_BLT:  cond_true_p0 = (rs1_s_p0 <  rs2_s_p0);
            `FUNC3_BGE:  cond_true_p0 = (rs1_s_p0 >= rs2_s_p0);
            `FUNC3_BLTU: cond_true_p0 = (i_rs1_data <  i_rs2_data);
            `FUNC3_BGEU: cond_true_p0 = (i_rs1_data >= i_rs2_data);
            default:     cond_known_p0 = 1'b0;
        endcase
    end

    assign jalr_sum_p0 = i_rs1_data + i_imm;
    assign target_p0   = (kind_p0 == KIND_JALR) ? {jalr_sum_p0[XLEN-1:1], 1'b0}
                                                : i_pc + i_imm;
    assign fall_pc_p0  = i_pc + XLEN'(4);

    always_comb begin
        case (kind_p0)
            KIND_BRANCH:       taken_p0 = cond_known_p0 & cond_true_p0;
            KIND_JAL, KIND_JALR: taken_p0 = 1'b1;
            default:           taken_p0 = 1'b0;
        endcase
    end

    assign redirect_p0   = taken_p0 ? target_p0 : fall_pc_p0;
    assign misaligned_p0 = taken_p0 & (target_p0[1:0] != 2'b00);

    // A misaligned target raises an exception instead of redirecting fetch.
    always_comb begin
        flush_p0 = 1'b0;
        if (is_control_flow(kind_p0) && !misaligned_p0) begin
            flush_p0 = taken_p0 ? (!i_pred_taken || (target_p0 != i_pred_pc))
                                : i_pred_taken;
        end
    end

    // While o_flush is high the instruction in EX is wrong-path: drop it.
    assign accept_p0  = i_valid & o_ready & ~i_stall & ~flush_p1;
    assign bht_upd_p0 = accept_p0 & (kind_p0 == KIND_BRANCH) & cond_known_p0;

    bht_2bit #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CTR_INIT    (CTR_INIT)
    ) u_bht (
        .clk          (clk),
        .rst          (rst),
        .lookup_idx   (i_lookup_pc[IDX_W+1:2]),
        .lookup_taken (o_lookup_taken),
        .upd_en       (bht_upd_p0),
        .upd_idx      (i_pc[IDX_W+1:2]),
        .upd_taken    (taken_p0),
        .ready        (o_ready)
    );

    assign unused_lookup_bits = ^{i_lookup_pc[XLEN-1:IDX_W+2], i_lookup_pc[1:0]};

    // ---- p1: output register (holds under stall; flush_p1 is also the kill shadow) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1        <= 1'b0;
            taken_p1      <= 1'b0;
            flush_p1      <= 1'b0;
            misaligned_p1 <= 1'b0;
            redirect_p1   <= '0;
        end else if (!i_stall) begin
            vld_p1        <= accept_p0;
            taken_p1      <= accept_p0 & taken_p0;
            flush_p1      <= accept_p0 & flush_p0;
            misaligned_p1 <= accept_p0 & misaligned_p0;
            if (accept_p0) begin
                redirect_p1 <= redirect_p0;
            end
        end
    end

    assign o_valid       = vld_p1;
    assign o_taken       = taken_p1;
    assign o_flush       = flush_p1;
    assign o_misaligned  = misaligned_p1;
    assign o_redirect_pc = redirect_p1;

endmodule
